// File: rtl/img_frame_arbiter.sv
// Frame-granular arbiter sharing one vsync/href/gray pipeline between two sources.
// Whole frames only, round-robin on ties, enforced vsync-low gap between frames.
module img_frame_arbiter #(
  parameter int DATA_W  = 8,
  parameter int MIN_GAP = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_en,
  input  logic              s0_img_vsync,
  input  logic              s0_img_href,
  input  logic [DATA_W-1:0] s0_img_gray,
  input  logic              s1_img_vsync,
  input  logic              s1_img_href,
  input  logic [DATA_W-1:0] s1_img_gray,
  output logic              post_img_vsync,
  output logic              post_img_href,
  output logic [DATA_W-1:0] post_img_gray,
  output logic              sel_id,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  drop_cnt0,
  output logic [CNT_W-1:0]  drop_cnt1
);

  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [GAP_W-1:0]    r_gap;
  logic [GAP_W-1:0]    w_gap_n;
  logic                r_s0_vd;
  logic                r_s1_vd;
  logic                r_armed;
  logic                r_last_id;
  logic                w_last_n;
  logic                r_sel_id;
  logic                w_sel_n;
  logic                r_busy;
  logic                r_done;
  logic                w_done_n;
  logic                r_vsync;
  logic                w_vsync_n;
  logic                r_href;
  logic                w_href_n;
  logic [DATA_W-1:0]   r_gray;
  logic [DATA_W-1:0]   w_gray_n;
  logic [CNT_W-1:0]    r_drop0;
  logic [CNT_W-1:0]    r_drop1;
  logic                w_inc0;
  logic                w_inc1;
  logic                w_rise0;
  logic                w_rise1;
  logic                w_grant;
  logic                w_g_vsync;
  logic                w_g_href;
  logic [DATA_W-1:0]   w_g_gray;
  logic                w_n_vsync;
  logic                w_n_href;
  logic [DATA_W-1:0]   w_n_gray;

  // The first cycle after reset is masked so a frame already running
  // at reset release never looks like a fresh frame start.
  assign w_rise0 = s0_img_vsync & ~r_s0_vd & cfg_en[0] & r_armed;
  assign w_rise1 = s1_img_vsync & ~r_s1_vd & cfg_en[1] & r_armed;

  assign w_grant = (w_rise0 & w_rise1) ? ~r_last_id : w_rise1;

  assign w_g_vsync = r_sel_id ? s1_img_vsync : s0_img_vsync;
  assign w_g_href  = r_sel_id ? s1_img_href  : s0_img_href;
  assign w_g_gray  = r_sel_id ? s1_img_gray  : s0_img_gray;

  assign w_n_vsync = w_grant ? s1_img_vsync : s0_img_vsync;
  assign w_n_href  = w_grant ? s1_img_href  : s0_img_href;
  assign w_n_gray  = w_grant ? s1_img_gray  : s0_img_gray;

  // Source vsync delay for frame-start edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_vd <= 1'b0;
      r_s1_vd <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_s0_vd <= s0_img_vsync;
      r_s1_vd <= s1_img_vsync;
      r_armed <= 1'b1;
    end
  end

  // Next-state, next-output and drop-event decode
  always_comb begin
    w_state_n = r_state;
    w_gap_n   = r_gap;
    w_sel_n   = r_sel_id;
    w_last_n  = r_last_id;
    w_vsync_n = 1'b0;
    w_href_n  = 1'b0;
    w_gray_n  = '0;
    w_done_n  = 1'b0;
    w_inc0    = 1'b0;
    w_inc1    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise0 | w_rise1) begin
          w_state_n = S_PASS;
          w_sel_n   = w_grant;
          w_last_n  = w_grant;
          w_vsync_n = w_n_vsync;
          w_href_n  = w_n_href;
          w_gray_n  = w_n_gray;
          w_inc0    = w_rise0 & w_rise1 & w_grant;
          w_inc1    = w_rise0 & w_rise1 & ~w_grant;
        end
      end
      S_PASS: begin
        w_inc0 = w_rise0 & r_sel_id;
        w_inc1 = w_rise1 & ~r_sel_id;
        if (w_g_vsync) begin
          w_vsync_n = 1'b1;
          w_href_n  = w_g_href;
          w_gray_n  = w_g_gray;
        end else begin
          w_done_n  = 1'b1;
          w_gap_n   = GAP_LOAD;
          w_state_n = S_GAP;
        end
      end
      S_GAP: begin
        w_inc0 = w_rise0;
        w_inc1 = w_rise1;
        if (r_gap == '0) begin
          w_state_n = S_IDLE;
        end else begin
          w_gap_n = r_gap - GAP_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // State, registered outputs and saturating drop counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gap     <= '0;
      r_sel_id  <= 1'b0;
      r_last_id <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_vsync   <= 1'b0;
      r_href    <= 1'b0;
      r_gray    <= '0;
      r_drop0   <= '0;
      r_drop1   <= '0;
    end else begin
      r_state   <= w_state_n;
      r_gap     <= w_gap_n;
      r_sel_id  <= w_sel_n;
      r_last_id <= w_last_n;
      r_busy    <= (w_state_n != S_IDLE);
      r_done    <= w_done_n;
      r_vsync   <= w_vsync_n;
      r_href    <= w_href_n;
      r_gray    <= w_gray_n;
      if (w_inc0 && (r_drop0 != CNT_MAX)) begin
        r_drop0 <= r_drop0 + CNT_W'(1);
      end
      if (w_inc1 && (r_drop1 != CNT_MAX)) begin
        r_drop1 <= r_drop1 + CNT_W'(1);
      end
    end
  end

  assign post_img_vsync = r_vsync;
  assign post_img_href  = r_href;
  assign post_img_gray  = r_gray;
  assign sel_id         = r_sel_id;
  assign busy           = r_busy;
  assign frame_done     = r_done;
  assign drop_cnt0      = r_drop0;
  assign drop_cnt1      = r_drop1;

endmodule
